dmem_port_arbiter: RTL

Shares data-memory port B between the CPU load/store unit and the debug/UART loader. Arbitrates with a round-robin policy and sequences each access onto the single synchronous BRAM port: word stores take one write, loads take one read, and byte/halfword stores take a read-modify-write. Each accepted request completes with a one-cycle `done` pulse back to its requester. The block sits between the MEM stage/loader and the `Mem` port-B pins, and replaces the free-running write-enable counter.

---
 rtl/dmem_port_arbiter.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter/sequencer for data-memory port B (CPU vs debug loader).
// Debug requester is built in only when DMEM_ARB_DBG_EN is defined.
module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic              dbg_we,
  input  logic [1:0]        dbg_size,
  input  logic              dbg_unsigned,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_done,
  output logic              dbg_err,
  output logic [31:0]       dbg_rdata,
  output logic [13:0]       mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t state_q, state_d;
  logic        gnt_q, gnt_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [13:0] maddr_q, maddr_d;
  logic        cdone_q, cdone_d, cerr_q, cerr_d;
  logic        ddone_q, ddone_d, derr_q, derr_d;
  logic [31:0] crdata_q, crdata_d, drdata_q, drdata_d;

  logic        sel_dbg, req_v, accept, bad;
  logic [15:0] req_addr;
  logic        req_we, req_uns;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        fin, fin_err;
  logic [31:0] fin_rd;
  logic [4:0]  sh;
  logic [31:0] lane, ext, mask, merged;

`ifdef DMEM_ARB_DBG_EN
  logic last_q, last_d;
  logic unused_bits;
  assign unused_bits = ^{cpu_addr[ADDR_W-1:16], dbg_addr[ADDR_W-1:16]};
  assign sel_dbg = dbg_req_valid & (~cpu_req_valid | ~last_q);
  assign req_v   = cpu_req_valid | dbg_req_valid;
`else
  logic unused_bits;
  assign unused_bits = ^{cpu_addr[ADDR_W-1:16], dbg_req_valid, dbg_addr,
                         dbg_we, dbg_size, dbg_unsigned, dbg_wdata};
  assign sel_dbg = 1'b0;
  assign req_v   = cpu_req_valid;
`endif

  assign accept = (state_q == IDLE) & req_v & ~rst;

  always_comb begin
    req_addr  = cpu_addr[15:0];
    req_we    = cpu_we;
    req_size  = cpu_size;
    req_uns   = cpu_unsigned;
    req_wdata = cpu_wdata;
`ifdef DMEM_ARB_DBG_EN
    if (sel_dbg) begin
      req_addr  = dbg_addr[15:0];
      req_we    = dbg_we;
      req_size  = dbg_size;
      req_uns   = dbg_unsigned;
      req_wdata = dbg_wdata;
    end
`endif
  end

  assign bad = (req_size == 2'd3)
             | ((req_size == 2'd1) & req_addr[0])
             | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));

  // Lane extract and merge work on the word captured in CAP.
  always_comb begin
    sh     = {addr_q[1:0], 3'b000};
    lane   = mem_rdata >> sh;
    ext    = mem_rdata;
    mask   = 32'hFFFF_FFFF;
    if (size_q == 2'd0) begin
      ext  = {{24{~uns_q & lane[7]}}, lane[7:0]};
      mask = 32'h0000_00FF << sh;
    end else if (size_q == 2'd1) begin
      ext  = {{16{~uns_q & lane[15]}}, lane[15:0]};
      mask = 32'h0000_FFFF << sh;
    end
    merged = (mem_rdata & ~mask) | ((wdata_q << sh) & mask);
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    maddr_d = maddr_q;
    fin     = 1'b0;
    fin_err = 1'b0;
    fin_rd  = 32'h0;
`ifdef DMEM_ARB_DBG_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          gnt_d   = sel_dbg;
`ifdef DMEM_ARB_DBG_EN
          last_d  = sel_dbg;
`endif
          addr_d  = req_addr;
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_uns;
          wdata_d = req_wdata;
          if (bad) begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end else begin
            maddr_d = req_addr[15:2];
            state_d = (req_we && req_size == 2'd2) ? WR : RD;
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        if (we_q) begin
          wdata_d = merged;
          state_d = WR;
        end else begin
          fin     = 1'b1;
          fin_rd  = ext;
          state_d = IDLE;
        end
      end
      WR: begin
        fin     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cdone_d  = fin & ~gnt_d;
    cerr_d   = fin_err & ~gnt_d;
    crdata_d = (fin & ~gnt_d) ? fin_rd : 32'h0;
    ddone_d  = fin & gnt_d;
    derr_d   = fin_err & gnt_d;
    drdata_d = (fin & gnt_d) ? fin_rd : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
      maddr_q  <= '0;
      cdone_q  <= 1'b0;
      cerr_q   <= 1'b0;
      crdata_q <= '0;
      ddone_q  <= 1'b0;
      derr_q   <= 1'b0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      wdata_q  <= wdata_d;
      maddr_q  <= maddr_d;
      cdone_q  <= cdone_d;
      cerr_q   <= cerr_d;
      crdata_q <= crdata_d;
      ddone_q  <= ddone_d;
      derr_q   <= derr_d;
      drdata_q <= drdata_d;
    end
  end

`ifdef DMEM_ARB_DBG_EN
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
  assign dbg_req_ready = accept & sel_dbg;
  assign dbg_done      = ddone_q;
  assign dbg_err       = derr_q;
  assign dbg_rdata     = drdata_q;
`else
  logic unused_dbg_regs;
  assign unused_dbg_regs = ^{ddone_q, derr_q, drdata_q};
  assign dbg_req_ready = 1'b0;
  assign dbg_done      = 1'b0;
  assign dbg_err       = 1'b0;
  assign dbg_rdata     = 32'h0;
`endif

  assign cpu_req_ready = accept & ~sel_dbg;
  assign cpu_done      = cdone_q;
  assign cpu_err       = cerr_q;
  assign cpu_rdata     = crdata_q;
  // A write never fires on a reset edge.
  assign mem_we        = (state_q == WR) & ~rst;
  assign mem_addr      = maddr_q;
  assign mem_wdata     = wdata_q;
  assign busy          = (state_q != IDLE);

endmodule
